// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the memory arbiter and its bench: word type,
// RAM status codes, arbiter state encoding and the streak counter width.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2,
    HIT    = 2'd3
  } state_t;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the pipeline ports, the RAM and the arbiter.
// Modport ma is the arbiter's view; tb is the view of whoever drives the
// pipeline requests and models the RAM.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  ramstate_t ramstate;
  word_t     ramload;

  logic      ihit;
  logic      dhit;
  word_t     imemload;
  word_t     dmemload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;

  modport ma (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    input  ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Registered arbiter between instruction fetch and data memory ports and a
// single-ported RAM. Data wins by default; after DSTREAK_MAX consecutive data
// grants with a fetch waiting, one fetch grant is forced.
//
// state  | meaning
// IDLE   | no transaction; pick the next owner
// IGRANT | fetch owns the RAM, strobe held until ACCESS or fetch drops
// DGRANT | data owns the RAM, strobe held until ACCESS (reads may abort)
// HIT    | one-cycle hit pulse; the completed request is ignored here
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DSTREAK_MAX = 4
) (
  input logic     CLK,
  input logic     nRST,
  mem_arbiter_if.ma bus
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(DSTREAK_MAX);

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic                d_pend;

  assign d_pend = bus.dREN | bus.dWEN;

  // Arbitration FSM; every output, including the RAM strobes, is a register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      streak       <= '0;
      bus.ihit     <= 1'b0;
      bus.dhit     <= 1'b0;
      bus.imemload <= '0;
      bus.dmemload <= '0;
      bus.ramREN   <= 1'b0;
      bus.ramWEN   <= 1'b0;
      bus.ramaddr  <= '0;
      bus.ramstore <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.iREN && (!d_pend || streak == STREAK_LIMIT)) begin
            state       <= IGRANT;
            streak      <= '0;
            bus.ramaddr <= bus.iaddr;
            bus.ramREN  <= 1'b1;
            bus.ramWEN  <= 1'b0;
          end else if (d_pend) begin
            // a simultaneous dREN/dWEN is serviced as a write
            state       <= DGRANT;
            bus.ramaddr <= bus.daddr;
            bus.ramWEN  <= bus.dWEN;
            bus.ramREN  <= ~bus.dWEN;
            if (bus.dWEN) bus.ramstore <= bus.dstore;
            if (bus.iREN) streak <= streak + 1'b1;
          end
        end
        IGRANT: begin
          if (!bus.iREN) begin
            // fetch flushed: quietly release the RAM
            bus.ramREN <= 1'b0;
            state      <= IDLE;
          end else if (bus.ramstate == ACCESS) begin
            bus.ramREN   <= 1'b0;
            bus.imemload <= bus.ramload;
            bus.ihit     <= 1'b1;
            state        <= HIT;
          end
        end
        DGRANT: begin
          if (bus.ramREN && !bus.dREN) begin
            // reads may be withdrawn; writes always run to completion
            bus.ramREN <= 1'b0;
            state      <= IDLE;
          end else if (bus.ramstate == ACCESS) begin
            if (bus.ramREN) bus.dmemload <= bus.ramload;
            bus.ramREN <= 1'b0;
            bus.ramWEN <= 1'b0;
            bus.dhit   <= 1'b1;
            state      <= HIT;
          end
        end
        HIT: begin
          bus.ihit <= 1'b0;
          bus.dhit <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions, then hand sequences
// for abort, mid-transaction reset and fetch starvation under contention.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  typedef struct {
    logic  is_d;
    logic  is_w;
    logic  both;
    word_t addr;
    word_t store;
    int    wait_cyc;
    logic  err;
    int    exp_lat;
  } vec_t;

  typedef struct {
    logic  is_d;
    logic  is_w;
    word_t addr;
    word_t store;
    word_t load;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;
  mem_arbiter_if bus ();

  mem_arbiter #(.DSTREAK_MAX(4)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus.ma)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  exp_t  sb[$];
  word_t exp_i = '0;
  word_t exp_d = '0;
  int    ram_wait = 0;
  logic  ram_err  = 1'b0;
  vec_t  vecs[8];

  function automatic word_t ram_word(word_t a);
    if (a == 32'h40) return 32'h8C22_0004;
    return (a * 32'h9E37_79B1) + 32'h1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // RAM model: BUSY/ERROR for ram_wait strobe cycles, then ACCESS with data
  initial begin
    int cnt;
    cnt = 0;
    bus.ramstate = FREE;
    bus.ramload  = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (bus.ramREN || bus.ramWEN) begin
        if (cnt < ram_wait) begin
          bus.ramstate = ram_err ? ERROR : BUSY;
          bus.ramload  = 32'hBAD0_BAD0;
          cnt++;
        end else begin
          bus.ramstate = ACCESS;
          bus.ramload  = ram_word(bus.ramaddr);
        end
      end else begin
        cnt = 0;
        bus.ramstate = FREE;
        bus.ramload  = 32'hBAD0_BAD0;
      end
    end
  end

  // Scoreboard monitor: strobes against the head entry, hits pop the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (nrst) begin
        check("hit_exclusive", 32'(bus.ihit & bus.dhit), 32'h0);
        if ((bus.ramREN || bus.ramWEN) && sb.size() > 0) begin
          e = sb[0];
          check("ramaddr", bus.ramaddr, e.addr);
          check("ramWEN", 32'(bus.ramWEN), 32'(e.is_w));
          check("ramREN", 32'(bus.ramREN), 32'(!e.is_w));
          if (e.is_w) check("ramstore", bus.ramstore, e.store);
        end
        if (bus.ihit || bus.dhit) begin
          if (sb.size() == 0) begin
            check("unexpected_hit", {30'h0, bus.ihit, bus.dhit}, 32'h0);
          end else begin
            e = sb.pop_front();
            check("hit_port", {30'h0, bus.ihit, bus.dhit}, e.is_d ? 32'h1 : 32'h2);
            if (!e.is_d) exp_i = e.load;
            else if (!e.is_w) exp_d = e.load;
          end
        end
        check("imemload", bus.imemload, exp_i);
        check("dmemload", bus.dmemload, exp_d);
      end
    end
  end

  task automatic run_vec(vec_t v);
    exp_t e;
    int   lat;
    e.is_d  = v.is_d;
    e.is_w  = v.is_w;
    e.addr  = v.addr;
    e.store = v.store;
    e.load  = ram_word(v.addr);
    sb.push_back(e);
    ram_wait = v.wait_cyc;
    ram_err  = v.err;
    if (v.is_d) begin
      bus.daddr  = v.addr;
      bus.dstore = v.store;
      bus.dWEN   = v.is_w;
      bus.dREN   = !v.is_w || v.both;
    end else begin
      bus.iaddr = v.addr;
      bus.iREN  = 1'b1;
    end
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.ihit || bus.dhit) begin
        lat = c;
        break;
      end
    end
    check("latency", lat, v.exp_lat);
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    if (sb.size() > 0) sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    vec_t v;
    int   dn;
    int   in;
    int   hits;

    // kind, write, both, addr, store, busy cycles, error, expected latency
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h40,  32'h0,         1, 1'b0, 3};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF,  3, 1'b0, 5};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h104, 32'h0,         0, 1'b0, 2};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h108, 32'h12345678,  2, 1'b0, 4};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h44,  32'h0,         0, 1'b0, 2};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h180, 32'h0,         5, 1'b1, 7};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h10C, 32'h0BADF00D,  0, 1'b0, 2};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h110, 32'hA5A5A5A5,  4, 1'b1, 6};

    nrst = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    #1;
    check("rst_strobes", {30'h0, bus.ramREN, bus.ramWEN}, 32'h0);
    check("rst_hits", {30'h0, bus.ihit, bus.dhit}, 32'h0);
    check("rst_ramaddr", bus.ramaddr, 32'h0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_streak", 32'(dut.streak), 32'h0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // fetch withdrawn while RAM is busy
    ram_wait = 30; ram_err = 1'b0;
    bus.iaddr = 32'h80; bus.iREN = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.ramREN) break;
    end
    check("abort_strobe_up", 32'(bus.ramREN), 32'h1);
    check("abort_addr", bus.ramaddr, 32'h80);
    bus.iREN = 1'b0;
    @(negedge clk);
    check("abort_strobe_drop", {30'h0, bus.ramREN, bus.ramWEN}, 32'h0);
    check("abort_no_ihit", 32'(bus.ihit), 32'h0);
    repeat (3) @(negedge clk);
    v = '{1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 1, 1'b0, 3};
    run_vec(v);

    // reset in the middle of a granted write
    ram_wait = 30;
    e = '{1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 32'h0};
    sb.push_back(e);
    bus.daddr = 32'h200; bus.dstore = 32'hCAFEF00D; bus.dWEN = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.ramWEN) break;
    end
    @(negedge clk);
    check("mid_write_held", 32'(bus.ramWEN), 32'h1);
    #2;
    nrst = 1'b0;
    sb.delete();
    exp_i = '0;
    exp_d = '0;
    #1;
    check("mrst_strobes", {30'h0, bus.ramREN, bus.ramWEN}, 32'h0);
    check("mrst_hits", {30'h0, bus.ihit, bus.dhit}, 32'h0);
    check("mrst_imemload", bus.imemload, 32'h0);
    check("mrst_dmemload", bus.dmemload, 32'h0);
    check("mrst_ramaddr", bus.ramaddr, 32'h0);
    check("mrst_ramstore", bus.ramstore, 32'h0);
    bus.dWEN = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    #1;
    check("mrst_state", 32'(dut.state), 32'(IDLE));
    check("mrst_streak", 32'(dut.streak), 32'h0);
    @(negedge clk);

    // contention: order must be D D D D I, twice
    ram_wait = 0;
    dn = 0; in = 0;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) begin
        e = '{1'b0, 1'b0, 32'h400 + 32'(4 * in), 32'h0, ram_word(32'h400 + 32'(4 * in))};
        in++;
      end else begin
        e = '{1'b1, 1'b0, 32'h200 + 32'(4 * dn), 32'h0, ram_word(32'h200 + 32'(4 * dn))};
        dn++;
      end
      sb.push_back(e);
    end
    dn = 0; in = 0; hits = 0;
    bus.iaddr = 32'h400; bus.iREN = 1'b1;
    bus.daddr = 32'h200; bus.dREN = 1'b1;
    for (int c = 0; c < 200 && hits < 10; c++) begin
      @(negedge clk);
      if (bus.dhit) begin
        dn++; hits++;
        bus.daddr = 32'h200 + 32'(4 * dn);
      end
      if (bus.ihit) begin
        in++; hits++;
        bus.iaddr = 32'h400 + 32'(4 * in);
      end
    end
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    check("cont_hits", hits, 10);
    check("cont_dhits", dn, 8);
    check("cont_ihits", in, 2);
    @(negedge clk);
    check("cont_sb_drained", sb.size(), 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
